dbg_step_ctrl: RTL and testbench



---
 rtl/dbg_pkg.sv | 20 ++
 rtl/dbg_step_ctrl_if.sv | 29 ++
 rtl/dbg_sync_edge.sv | 46 ++++
 rtl/dbg_step_ctrl.sv | 145 ++++++++++++++
 tb/tb_dbg_step_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug execution controller and its
// register-file snapshot sequencer.
package dbg_pkg;

  localparam int XLEN     = 32;
  localparam int NREGS    = 32;
  localparam int SNAP_LEN = 33;

  localparam logic [5:0] PC_IDX    = 6'd32;
  // Dump cycles run d0..d33; the last one writes the PC entry.
  localparam logic [5:0] DUMP_LAST = 6'(SNAP_LEN);

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_DUMP   = 2'd3
  } state_e;

endpackage

// File: rtl/dbg_step_ctrl_if.sv
// Register-file debug read port plus snapshot write stream between the
// execution controller (master) and the core / capture registers (slave).
interface dbg_step_ctrl_if #(
  parameter int XLEN = 32
);

  logic [4:0]      rf_dbg_addr;
  logic [XLEN-1:0] rf_dbg_data;
  logic            snap_we;
  logic [5:0]      snap_idx;
  logic [XLEN-1:0] snap_data;

  modport master (
    output rf_dbg_addr,
    output snap_we,
    output snap_idx,
    output snap_data,
    input  rf_dbg_data
  );

  modport slave (
    input  rf_dbg_addr,
    input  snap_we,
    input  snap_idx,
    input  snap_data,
    output rf_dbg_data
  );

endinterface

// File: rtl/dbg_sync_edge.sv
// Multi-flop synchroniser for an asynchronous host level, with an optional
// one-cycle rising-edge pulse taken after the last synchroniser stage.
module dbg_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_EN     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], async_i};

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours and the chain shifts by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign level_o = sync_q[SYNC_STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;
      logic prev_d;

      always_comb prev_d = level_o;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= prev_d;
      end

      assign pulse_o = level_o & ~prev_q;
    end else begin : g_level
      assign pulse_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/dbg_step_ctrl.sv
// Debug execution controller: gates the core clock-enable for run / halt /
// N-cycle step and streams an x0..x31 + PC snapshot on every halt.
module dbg_step_ctrl
  import dbg_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int XLEN        = dbg_pkg::XLEN
) (
  input  logic             dbg_clk_clk,
  input  logic             dbg_reset_reset_n,
  input  logic             host_run,
  input  logic             host_step,
  input  logic [CNT_W-1:0] step_count,
  input  logic [XLEN-1:0]  core_pc,
  output logic             core_ce,
  output logic             halted,
  output logic             snap_valid,
  dbg_step_ctrl_if.master  dbg_bus
);

  logic run_s;
  logic step_p;

  dbg_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_EN     (1'b0)
  ) u_run_sync (
    .clk     (dbg_clk_clk),
    .rst_n   (dbg_reset_reset_n),
    .async_i (host_run),
    .level_o (run_s),
    .pulse_o ()
  );

  dbg_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_EN     (1'b1)
  ) u_step_sync (
    .clk     (dbg_clk_clk),
    .rst_n   (dbg_reset_reset_n),
    .async_i (host_step),
    .level_o (),
    .pulse_o (step_p)
  );

  state_e          state_q,      state_d;
  logic [CNT_W-1:0] step_cnt_q,  step_cnt_d;
  logic [5:0]      dump_cnt_q,   dump_cnt_d;
  logic [XLEN-1:0] pc_q,         pc_d;
  logic            snap_valid_q, snap_valid_d;

  // NOTE: every output and next-state variable gets a default before the
  // case statement so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    step_cnt_d   = step_cnt_q;
    dump_cnt_d   = dump_cnt_q;
    pc_d         = pc_q;
    snap_valid_d = snap_valid_q;

    core_ce           = 1'b0;
    halted            = 1'b0;
    dbg_bus.rf_dbg_addr = 5'd0;
    dbg_bus.snap_we     = 1'b0;
    dbg_bus.snap_idx    = 6'd0;
    dbg_bus.snap_data   = '0;

    unique case (state_q)
      ST_HALTED: begin
        halted = 1'b1;
        // Run wins a same-cycle tie; the coincident step pulse is lost.
        if (run_s) begin
          state_d      = ST_RUN;
          snap_valid_d = 1'b0;
        end else if (step_p) begin
          state_d      = ST_STEP;
          step_cnt_d   = (step_count == '0) ? CNT_W'(1) : step_count;
          snap_valid_d = 1'b0;
        end
      end

      ST_RUN: begin
        // Enable drops in the same cycle the synchronised run level falls.
        if (run_s) begin
          core_ce = 1'b1;
        end else begin
          state_d    = ST_DUMP;
          dump_cnt_d = 6'd0;
          pc_d       = core_pc;
        end
      end

      ST_STEP: begin
        core_ce = 1'b1;
        if (step_cnt_q == CNT_W'(1)) begin
          state_d    = ST_DUMP;
          step_cnt_d = '0;
          dump_cnt_d = 6'd0;
          pc_d       = core_pc;
        end else begin
          step_cnt_d = step_cnt_q - CNT_W'(1);
        end
      end

      ST_DUMP: begin
        if (dump_cnt_q < 6'(NREGS)) dbg_bus.rf_dbg_addr = dump_cnt_q[4:0];
        // Read data trails the address by one cycle, so entry i lands on d(i+1).
        if (dump_cnt_q != 6'd0) begin
          dbg_bus.snap_we  = 1'b1;
          dbg_bus.snap_idx = dump_cnt_q - 6'd1;
          dbg_bus.snap_data = (dump_cnt_q == DUMP_LAST) ? pc_q : dbg_bus.rf_dbg_data;
        end
        if (dump_cnt_q == DUMP_LAST) begin
          state_d      = ST_HALTED;
          dump_cnt_d   = 6'd0;
          snap_valid_d = 1'b1;
        end else begin
          dump_cnt_d = dump_cnt_q + 6'd1;
        end
      end

      default: state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge dbg_clk_clk or negedge dbg_reset_reset_n) begin
    if (!dbg_reset_reset_n) begin
      state_q      <= ST_HALTED;
      step_cnt_q   <= '0;
      dump_cnt_q   <= 6'd0;
      pc_q         <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_cnt_q   <= step_cnt_d;
      dump_cnt_q   <= dump_cnt_d;
      pc_q         <= pc_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_dbg_step_ctrl.sv
// Directed bench for dbg_step_ctrl: table of step lengths plus hand-written
// run, run/step tie, step-during-dump and reset-during-dump sequences.
module tb_dbg_step_ctrl;

  localparam int CNT_W = 16;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             host_run;
  logic             host_step;
  logic [CNT_W-1:0] step_count;
  logic [31:0]      core_pc = 32'h0000_1000;
  logic             core_ce;
  logic             halted;
  logic             snap_valid;

  dbg_step_ctrl_if #(.XLEN(32)) bus ();

  dbg_step_ctrl #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC),
    .XLEN        (32)
  ) dut (
    .dbg_clk_clk       (clk),
    .dbg_reset_reset_n (rst_n),
    .host_run          (host_run),
    .host_step         (host_step),
    .step_count        (step_count),
    .core_pc           (core_pc),
    .core_ce           (core_ce),
    .halted            (halted),
    .snap_valid        (snap_valid),
    .dbg_bus           (bus)
  );

  always #5 clk = ~clk;

  // Core model: register file x_i = A5A50000+i with one-cycle read latency,
  // PC advancing by 4 on every enabled cycle.
  always @(posedge clk) bus.rf_dbg_data <= 32'hA5A5_0000 + {27'd0, bus.rf_dbg_addr};
  always @(posedge clk) if (core_ce) core_pc <= core_pc + 32'd4;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [5:0]  idx;
    logic [31:0] data;
  } we_rec_t;

  we_rec_t we_q[$];
  int      ce_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (core_ce) ce_q.push_back(cyc);
      if (bus.snap_we) we_q.push_back('{c: cyc, idx: bus.snap_idx, data: bus.snap_data});
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dump(input string tag, input int we_base);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      if (we_q.size() >= we_base + 33) done = 1'b1;
    end
    if (!done) check({tag, "_timeout"}, 64'(we_q.size() - we_base), 64'd33);
  endtask

  // Checks 33 ordered entries, their data, and the gap from last enabled cycle.
  task automatic check_dump(input string tag, input int we_base, input logic [31:0] exp_pc,
                            input int exp_gap);
    check({tag, "_we_count"}, 64'(we_q.size() - we_base), 64'd33);
    if (we_q.size() >= we_base + 33) begin
      for (int k = 0; k < 33; k++) begin
        check($sformatf("%s_idx%0d", tag, k), 64'(we_q[we_base+k].idx), 64'(k));
        if (k < 32)
          check($sformatf("%s_x%0d", tag, k), 64'(we_q[we_base+k].data), 64'(32'hA5A5_0000 + k));
        else
          check({tag, "_pc"}, 64'(we_q[we_base+k].data), 64'(exp_pc));
      end
      check({tag, "_we_contig"}, 64'(we_q[we_base+32].c - we_q[we_base].c), 64'd32);
      if (ce_q.size() > 0)
        check({tag, "_dump_gap"}, 64'(we_q[we_base].c - ce_q[$]), 64'(exp_gap));
    end
    check({tag, "_halted"}, 64'(halted), 64'd1);
    check({tag, "_snap_valid"}, 64'(snap_valid), 64'd1);
  endtask

  typedef struct {
    string            name;
    logic [CNT_W-1:0] cnt;
    int               exp_ce;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int c0, c1, we_base, ce_base;
    logic [31:0] pc_start;
    bit found;

    vecs[0] = '{name: "step5", cnt: 16'd5, exp_ce: 5};
    vecs[1] = '{name: "step0", cnt: 16'd0, exp_ce: 1};
    vecs[2] = '{name: "step1", cnt: 16'd1, exp_ce: 1};
    vecs[3] = '{name: "step3", cnt: 16'd3, exp_ce: 3};
    vecs[4] = '{name: "step2", cnt: 16'd2, exp_ce: 2};

    rst_n = 1'b0; host_run = 1'b0; host_step = 1'b0; step_count = '0;
    repeat (3) tick();
    check("rst_core_ce", 64'(core_ce), 64'd0);
    check("rst_halted", 64'(halted), 64'd1);
    check("rst_snap_valid", 64'(snap_valid), 64'd0);
    check("rst_snap_we", 64'(bus.snap_we), 64'd0);
    check("rst_rf_addr", 64'(bus.rf_dbg_addr), 64'd0);
    rst_n = 1'b1;

    repeat (100) tick();
    check("idle_we_count", 64'(we_q.size()), 64'd0);
    check("idle_ce_count", 64'(ce_q.size()), 64'd0);
    check("idle_halted", 64'(halted), 64'd1);
    check("idle_snap_valid", 64'(snap_valid), 64'd0);
    check("idle_snap_idx", 64'(bus.snap_idx), 64'd0);
    check("idle_snap_data", 64'(bus.snap_data), 64'd0);

    foreach (vecs[v]) begin
      we_base = we_q.size(); ce_base = ce_q.size();
      pc_start = core_pc;
      step_count = vecs[v].cnt;
      c0 = cyc;
      host_step = 1'b1;
      repeat (4) tick();
      check({vecs[v].name, "_valid_cleared"}, 64'(snap_valid), 64'd0);
      check({vecs[v].name, "_not_halted"}, 64'(halted), 64'd0);
      wait_dump(vecs[v].name, we_base);
      check({vecs[v].name, "_ce_len"}, 64'(ce_q.size() - ce_base), 64'(vecs[v].exp_ce));
      if (ce_q.size() > ce_base) begin
        check({vecs[v].name, "_ce_start"}, 64'(ce_q[ce_base] - c0), 64'(SYNC + 1));
        check({vecs[v].name, "_ce_contig"}, 64'(ce_q[$] - ce_q[ce_base] + 1), 64'(vecs[v].exp_ce));
      end
      check_dump(vecs[v].name, we_base, pc_start + 32'(4 * (vecs[v].exp_ce - 1)), 2);
      host_step = 1'b0;
      repeat (5) tick();
    end

    // Second step edge arriving mid-dump must not start another step.
    we_base = we_q.size(); ce_base = ce_q.size();
    pc_start = core_pc;
    step_count = '0;
    host_step = 1'b1;
    repeat (8) tick();
    host_step = 1'b0;
    repeat (4) tick();
    host_step = 1'b1;
    wait_dump("redge", we_base);
    check_dump("redge", we_base, pc_start, 2);
    repeat (40) tick();
    check("redge_ce_total", 64'(ce_q.size() - ce_base), 64'd1);
    check("redge_we_total", 64'(we_q.size() - we_base), 64'd33);
    host_step = 1'b0;
    repeat (5) tick();

    // Free-run for 50 cycles, then release.
    we_base = we_q.size(); ce_base = ce_q.size();
    c0 = cyc;
    host_run = 1'b1;
    repeat (50) tick();
    c1 = cyc;
    host_run = 1'b0;
    wait_dump("run", we_base);
    check("run_ce_len", 64'(ce_q.size() - ce_base), 64'd49);
    if (ce_q.size() > ce_base) begin
      check("run_ce_start", 64'(ce_q[ce_base] - c0), 64'(SYNC + 1));
      check("run_ce_contig", 64'(ce_q[$] - ce_q[ce_base] + 1), 64'd49);
      check("run_ce_fall_bound", 64'((ce_q[$] - c1) <= SYNC + 1), 64'd1);
    end
    check_dump("run", we_base, core_pc, 3);
    repeat (5) tick();

    // Run and step rising together: run wins, the step is dropped.
    we_base = we_q.size(); ce_base = ce_q.size();
    host_run = 1'b1; host_step = 1'b1;
    repeat (20) tick();
    check("tie_no_dump_in_run", 64'(we_q.size() - we_base), 64'd0);
    check("tie_running", 64'(core_ce), 64'd1);
    host_run = 1'b0;
    wait_dump("tie", we_base);
    check_dump("tie", we_base, core_pc, 3);
    repeat (40) tick();
    check("tie_single_dump", 64'(we_q.size() - we_base), 64'd33);
    if (ce_q.size() > ce_base)
      check("tie_ce_contig", 64'(ce_q[$] - ce_q[ce_base] + 1), 64'(ce_q.size() - ce_base));
    check("tie_halted_after", 64'(halted), 64'd1);
    host_step = 1'b0;
    repeat (5) tick();

    // Reset pulsed at dump cycle d10 (the cycle carrying idx 9).
    step_count = 16'd4;
    host_step = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (bus.snap_we && bus.snap_idx == 6'd9) found = 1'b1;
    end
    check("rstd_reached_d10", 64'(found), 64'd1);
    check("rstd_addr_before", 64'(bus.rf_dbg_addr), 64'd10);
    #2 rst_n = 1'b0;
    #1;
    check("rstd_core_ce", 64'(core_ce), 64'd0);
    check("rstd_halted", 64'(halted), 64'd1);
    check("rstd_snap_valid", 64'(snap_valid), 64'd0);
    check("rstd_snap_we", 64'(bus.snap_we), 64'd0);
    check("rstd_snap_idx", 64'(bus.snap_idx), 64'd0);
    check("rstd_snap_data", 64'(bus.snap_data), 64'd0);
    check("rstd_rf_addr", 64'(bus.rf_dbg_addr), 64'd0);
    host_step = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    we_base = we_q.size(); ce_base = ce_q.size();
    repeat (60) tick();
    check("rstd_no_more_we", 64'(we_q.size() - we_base), 64'd0);
    check("rstd_no_ce", 64'(ce_q.size() - ce_base), 64'd0);
    check("rstd_valid_after", 64'(snap_valid), 64'd0);
    check("rstd_halted_after", 64'(halted), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
